// File: rtl/match_drv_pkg.sv
// Shared operation/state types and dispatch selector codes for match_dispatch_driver.
package match_drv_pkg;

    typedef enum logic [1:0] {
        OP_INC = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MUL = 2'd3
    } match_op_t;

    localparam int CODE_INC = 17;
    localparam int CODE_ADD = 21;
    localparam int CODE_SUB = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } drv_state_t;

    // True when a MUL left operand would be decoded by the dispatch unit as another op.
    function automatic logic is_alias_code(input logic [31:0] v);
        return (v == 32'(CODE_INC)) || (v == 32'(CODE_ADD)) || (v == 32'(CODE_SUB));
    endfunction

endpackage

// File: rtl/match_dispatch_driver_if.sv
// Request, response, dispatch-unit and statistics signals of match_dispatch_driver.
interface match_dispatch_driver_if #(
    parameter int NBITS = 8
);
    // Handshakes: a transfer happens on a rising CLK edge where VALID and READY are both
    // high; once VALID is raised the sender holds VALID and its payload until that edge.
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [1:0]       REQ_OP;
    logic [NBITS-1:0] REQ_A;
    logic [NBITS-1:0] REQ_B;
    logic [NBITS-1:0] A;
    logic [NBITS-1:0] B;
    logic [NBITS-1:0] XOUT;
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [NBITS-1:0] RSP_DATA;
    logic             RSP_ERR;
    logic [15:0]      STAT_REQS;
    logic [15:0]      STAT_ERRS;

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_A, REQ_B, XOUT, RSP_READY,
        output REQ_READY, A, B, RSP_VALID, RSP_DATA, RSP_ERR, STAT_REQS, STAT_ERRS
    );

    modport master (
        output REQ_VALID, REQ_OP, REQ_A, REQ_B, XOUT, RSP_READY,
        input  REQ_READY, A, B, RSP_VALID, RSP_DATA, RSP_ERR, STAT_REQS, STAT_ERRS
    );

endinterface

// File: rtl/match_op_encoder.sv
// Combinational mapping of an abstract request onto the dispatch unit's selector/operands.
module match_op_encoder
    import match_drv_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  match_op_t        op,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic [NBITS-1:0] a,
    output logic [NBITS-1:0] b,
    output logic             illegal
);

    always_comb begin
        a       = req_a;
        b       = req_b;
        illegal = 1'b0;
        case (op)
            OP_INC: begin
                a = NBITS'(CODE_INC);
                b = '0;
            end
            OP_ADD: a = NBITS'(CODE_ADD);
            OP_SUB: a = NBITS'(CODE_SUB);
            OP_MUL: illegal = is_alias_code(32'(req_a));
            default: illegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/match_dispatch_driver.sv
// Sequential initiator for the opcode-dispatch unit; one outstanding request at a time.
// Optional saturating request/error counters are built when MATCH_DRV_STATS_EN is defined.
module match_dispatch_driver
    import match_drv_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int LAT   = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    match_dispatch_driver_if.slave  bus,
    output drv_state_t              dbg_state
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    drv_state_t       state;
    drv_state_t       state_next;
    logic             started;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] data_q;
    logic             err_q;
    logic [NBITS-1:0] enc_a;
    logic [NBITS-1:0] enc_b;
    logic             enc_illegal;
    logic             accept;
    logic             capture;

    match_op_encoder #(.NBITS(NBITS)) u_encoder (
        .op      (match_op_t'(bus.REQ_OP)),
        .req_a   (bus.REQ_A),
        .req_b   (bus.REQ_B),
        .a       (enc_a),
        .b       (enc_b),
        .illegal (enc_illegal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (started && bus.REQ_VALID) begin
                    accept     = 1'b1;
                    state_next = enc_illegal ? HOLD : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.RSP_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // started keeps REQ_READY low until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            started <= 1'b0;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                if (enc_illegal) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end else begin
                    a_q <= enc_a;
                    b_q <= enc_b;
                    cnt <= CW'(LAT - 1);
                end
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                data_q <= bus.XOUT;
                err_q  <= 1'b0;
            end
        end
    end

    assign bus.REQ_READY = started && (state == IDLE);
    assign bus.RSP_VALID = (state == HOLD);
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.RSP_DATA  = data_q;
    assign bus.RSP_ERR   = err_q;
    assign dbg_state     = state;

`ifdef MATCH_DRV_STATS_EN
    logic [15:0] stat_reqs;
    logic [15:0] stat_errs;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_reqs <= '0;
            stat_errs <= '0;
        end else if (accept) begin
            if (stat_reqs != 16'hFFFF) stat_reqs <= stat_reqs + 16'd1;
            if (enc_illegal && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end
    end

    assign bus.STAT_REQS = stat_reqs;
    assign bus.STAT_ERRS = stat_errs;
`else
    assign bus.STAT_REQS = '0;
    assign bus.STAT_ERRS = '0;
`endif

endmodule

// File: tb/tb_match_dispatch_driver.sv
// Directed plus randomized bench for match_dispatch_driver with a behavioural dispatch unit.
module tb_match_dispatch_driver;
    import match_drv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n3;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    match_dispatch_driver_if #(.NBITS(8)) bus1();
    match_dispatch_driver_if #(.NBITS(8)) bus3();
    drv_state_t dbg1;
    drv_state_t dbg3;

    match_dispatch_driver #(.NBITS(8), .LAT(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .bus(bus1), .dbg_state(dbg1)
    );
    match_dispatch_driver #(.NBITS(8), .LAT(3)) dut3 (
        .CLK(clk), .RST_N(rst_n3), .bus(bus3), .dbg_state(dbg3)
    );

    // Behavioural dispatch unit the driver talks to.
    function automatic logic [7:0] dispatch(input logic [7:0] a, input logic [7:0] b);
        case (a)
            8'd17:   return a + 8'd1;
            8'd21:   return a + b;
            8'd34:   return a - b;
            default: return 8'(a * b);
        endcase
    endfunction

    assign bus1.XOUT = dispatch(bus1.A, bus1.B);
    assign bus3.XOUT = dispatch(bus3.A, bus3.B);

    // Reference model state: {err, data} expectations and the last legal encoding.
    logic [8:0] exp_q[$];
    int model_a = 0;
    int model_b = 0;
    int exp_reqs = 0;
    int exp_errs = 0;
    int last_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_rsp(input int op, input int a, input int b);
        if (op == 3 && (a == 17 || a == 21 || a == 34)) return {1'b1, 8'd0};
        case (op)
            0:       return {1'b0, 8'd18};
            1:       return {1'b0, 8'((21 + b) % 256)};
            2:       return {1'b0, 8'((34 - b + 256) % 256)};
            default: return {1'b0, 8'((a * b) % 256)};
        endcase
    endfunction

    task automatic check_stats(input string tag);
`ifdef MATCH_DRV_STATS_EN
        check({tag, "_stat_reqs"}, 32'(bus1.STAT_REQS), exp_reqs);
        check({tag, "_stat_errs"}, 32'(bus1.STAT_ERRS), exp_errs);
`else
        check({tag, "_stat_reqs"}, 32'(bus1.STAT_REQS), 0);
        check({tag, "_stat_errs"}, 32'(bus1.STAT_ERRS), 0);
`endif
    endtask

    task automatic run_txn(input int op, input int a, input int b, input int stall);
        logic [8:0] e;
        int n;
        bus1.REQ_OP    = 2'(op);
        bus1.REQ_A     = 8'(a);
        bus1.REQ_B     = 8'(b);
        bus1.REQ_VALID = 1'b1;
        n = 0;
        while (!bus1.REQ_READY && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", 32'(bus1.REQ_READY), 1);
        @(posedge clk); #1;
        last_acc = cyc;
        bus1.REQ_VALID = 1'b0;
        e = model_rsp(op, a, b);
        exp_q.push_back(e);
        exp_reqs++;
        if (e[8]) exp_errs++;
        else begin
            case (op)
                0:       begin model_a = 17; model_b = 0; end
                1:       begin model_a = 21; model_b = b; end
                2:       begin model_a = 34; model_b = b; end
                default: begin model_a = a;  model_b = b; end
            endcase
        end
        check("req_ready_busy", 32'(bus1.REQ_READY), 0);
        check("a_out", 32'(bus1.A), model_a);
        check("b_out", 32'(bus1.B), model_b);
        n = 0;
        while (!bus1.RSP_VALID && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("rsp_valid", 32'(bus1.RSP_VALID), 1);
        if (!e[8]) check("rsp_latency", n, 1);
        e = exp_q.pop_front();
        check("rsp_data", 32'(bus1.RSP_DATA), 32'(e[7:0]));
        check("rsp_err", 32'(bus1.RSP_ERR), 32'(e[8]));
        check_stats("txn");
        bus1.RSP_READY = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(bus1.RSP_VALID), 1);
            check("stall_data", 32'(bus1.RSP_DATA), 32'(e[7:0]));
            check("stall_err", 32'(bus1.RSP_ERR), 32'(e[8]));
            check("stall_req_ready", 32'(bus1.REQ_READY), 0);
        end
        bus1.RSP_READY = 1'b1;
        @(posedge clk); #1;
        bus1.RSP_READY = 1'b0;
        check("post_rsp_ready", 32'(bus1.REQ_READY), 1);
        check("post_rsp_valid", 32'(bus1.RSP_VALID), 0);
    endtask

    initial begin
        int acc1;
        int n;
        int seen;
        int op;
        int a;
        int codes[3] = '{17, 21, 34};

        rst_n = 1'b0;
        rst_n3 = 1'b0;
        bus1.REQ_VALID = 1'b0; bus1.REQ_OP = 2'd0; bus1.REQ_A = '0; bus1.REQ_B = '0;
        bus1.RSP_READY = 1'b0;
        bus3.REQ_VALID = 1'b0; bus3.REQ_OP = 2'd0; bus3.REQ_A = '0; bus3.REQ_B = '0;
        bus3.RSP_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus1.REQ_READY), 0);
        check("rst_rsp_valid", 32'(bus1.RSP_VALID), 0);
        check("rst_rsp_err", 32'(bus1.RSP_ERR), 0);
        check("rst_rsp_data", 32'(bus1.RSP_DATA), 0);
        check("rst_a", 32'(bus1.A), 0);
        check("rst_b", 32'(bus1.B), 0);
        check("rst_state", 32'(dbg1), 32'(IDLE));
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        rst_n3 = 1'b1;
        check("release_req_ready", 32'(bus1.REQ_READY), 0);
        @(posedge clk); #1;
        check("first_edge_req_ready", 32'(bus1.REQ_READY), 1);

        // Directed cases.
        run_txn(0, 0, 99, 0);
        run_txn(1, 0, 5, 0);
        acc1 = last_acc;
        run_txn(2, 0, 40, 0);
        check("throughput", last_acc - acc1, 3);
        run_txn(3, 3, 7, 0);
        run_txn(3, 20, 20, 0);
        run_txn(3, 21, 9, 0);
        run_txn(1, 0, 77, 4);

        // Randomized traffic, biased towards aliasing MUL operands.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            a = (op == 3 && $urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 2)]
                                                       : $urandom_range(0, 255);
            run_txn(op, a, $urandom_range(0, 255), $urandom_range(0, 3));
        end

        // LAT=3 instance: latency, then reset in the middle of WAIT.
        bus3.REQ_OP = 2'd1; bus3.REQ_B = 8'd7; bus3.REQ_VALID = 1'b1;
        @(posedge clk); #1;
        bus3.REQ_VALID = 1'b0;
        n = 0;
        while (!bus3.RSP_VALID && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("lat3_latency", n, 3);
        check("lat3_data", 32'(bus3.RSP_DATA), 28);
        bus3.RSP_READY = 1'b1;
        @(posedge clk); #1;
        bus3.RSP_READY = 1'b0;
        bus3.REQ_OP = 2'd2; bus3.REQ_B = 8'd4; bus3.REQ_VALID = 1'b1;
        @(posedge clk); #1;
        bus3.REQ_VALID = 1'b0;
        @(posedge clk); #1;
        check("lat3_in_wait", 32'(dbg3), 32'(WAIT));
        #2;
        rst_n3 = 1'b0;
        #1;
        check("wait_rst_state", 32'(dbg3), 32'(IDLE));
        check("wait_rst_req_ready", 32'(bus3.REQ_READY), 0);
        check("wait_rst_a", 32'(bus3.A), 0);
        check("wait_rst_b", 32'(bus3.B), 0);
        check("wait_rst_rsp_valid", 32'(bus3.RSP_VALID), 0);
        check("wait_rst_rsp_data", 32'(bus3.RSP_DATA), 0);
        @(negedge clk);
        rst_n3 = 1'b1;
        @(posedge clk); #1;
        check("wait_rst_release_ready", 32'(bus3.REQ_READY), 1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus3.RSP_VALID) seen++;
        end
        check("wait_rst_no_response", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
